// File: rtl/sigmoid_out_requant_if.sv
// rtl/sigmoid_out_requant_if.sv - sample stream in and requantized stream out of sigmoid_out_requant
// The slave modport is the requantizer's view; master is the surrounding producer/consumer view.
interface sigmoid_out_requant_if #(
  parameter int WIDTH_Y = 33,
  parameter int OUT_W   = 16
);
  logic               in_valid;
  logic [WIDTH_Y-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/sigmoid_out_requant.sv
// rtl/sigmoid_out_requant.sv - round/saturate sigmoid output to OUT_W bits and buffer it in a FWFT FIFO
// Define SIGMOID_REQ_SATCNT_EN to build the saturated-sample counter; otherwise sat_cnt is tied to 0.
module sigmoid_out_requant #(
  parameter int WIDTH_Y  = 33,
  parameter int OUT_W    = 16,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  sigmoid_out_requant_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              sat_cnt
);

  localparam int SH = WIDTH_Y - 1 - OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH_Y:0] HALF  = {{WIDTH_Y{1'b0}}, 1'b1} << (SH - 1);
  localparam logic [AW:0]      AF_LVL = AFULL_TH[AW:0];

  // One extra bit of headroom so adding the rounding half can never wrap.
  logic [WIDTH_Y:0]   sum;
  logic               over;
  logic [OUT_W-1:0]   q;
  logic               unused_frac;

  assign sum         = {1'b0, bus.in_data} + HALF;
  assign over        = |sum[WIDTH_Y:SH+OUT_W];
  assign q           = over ? {OUT_W{1'b1}} : sum[SH+OUT_W-1:SH];
  assign unused_frac = ^sum[SH-1:0];

  logic             s1_valid;
  logic [OUT_W-1:0] s1_data;
  logic             s1_sat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_data  <= q;
      s1_sat   <= bus.in_valid & over;
    end
  end

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      count_n;
  logic             full;
  logic             pop;
  logic             wr;
  logic             drop;

  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop  = bus.out_valid & bus.out_ready;
  // Upstream cannot stall: a full FIFO only accepts when the head leaves in the same cycle.
  assign wr   = s1_valid & (~full | pop);
  assign drop = s1_valid & full & ~pop;

  always_comb begin
    count_n = count;
    case ({wr, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      bus.out_valid <= 1'b0;
      almost_full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr[AW-1:0]] <= s1_data;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count         <= count_n;
      bus.out_valid <= (count_n != '0);
      almost_full   <= (count_n >= AF_LVL);
    end
  end

  assign bus.out_data = mem[rptr[AW-1:0]];

  // A drop in the clearing cycle wins so that loss is never silently hidden.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      ovf      <= drop;
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef SIGMOID_REQ_SATCNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sat_cnt <= '0;
    end else if (s1_valid && s1_sat && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = s1_sat;
  assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_sigmoid_out_requant.sv
// tb/tb_sigmoid_out_requant.sv - scoreboard bench for sigmoid_out_requant
// Stimulus pushes expected words; a negedge monitor pops and compares on every handshake.
module tb_sigmoid_out_requant;

`ifdef SIGMOID_REQ_SATCNT_EN
  localparam logic [15:0] EXP_SAT = 16'd2;
`else
  localparam logic [15:0] EXP_SAT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [4:0]  count;
  logic        almost_full;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic [15:0] sat_cnt;

  sigmoid_out_requant_if #(.WIDTH_Y(33), .OUT_W(16)) bus ();

  sigmoid_out_requant #(.WIDTH_Y(33), .OUT_W(16), .DEPTH(16), .AFULL_TH(12)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .count       (count),
    .almost_full (almost_full),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .drop_cnt    (drop_cnt),
    .sat_cnt     (sat_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [32:0] d, input logic keep, input logic [15:0] e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (keep) sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got %0h expected no output", bus.out_data);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_data", {16'h0, bus.out_data}, {16'h0, mon_exp});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [32:0] rv [5];
  logic [15:0] re [5];
  int          minc;

  initial begin
    rv = '{33'h0_8000_0000, 33'h0_0000_7FFF, 33'h0_0000_8000, 33'h1_0000_0000, 33'h0_FFFF_8000};
    re = '{16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset values
    tick();
    tick();
    check("rst_count", {27'h0, count}, 32'd0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'h0, bus.out_data}, 32'd0);
    check("rst_almost_full", {31'h0, almost_full}, 32'd0);
    check("rst_ovf", {31'h0, ovf}, 32'd0);
    check("rst_drop_cnt", {16'h0, drop_cnt}, 32'd0);
    check("rst_sat_cnt", {16'h0, sat_cnt}, 32'd0);
    rstn = 1'b1;

    // rounding and saturation, two-edge latency
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(rv[i], 1'b1, re[i]);
      tick();
      check("lat_valid", {31'h0, bus.out_valid}, 32'd1);
      check("lat_data", {16'h0, bus.out_data}, {16'h0, re[i]});
    end
    tick();
    tick();
    check("sat_cnt", {16'h0, sat_cnt}, {16'h0, EXP_SAT});
    check("round_drained", {27'h0, count}, 32'd0);

    // overflow: 18 samples into 16 entries
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 18; k++) send(33'(k) << 16, k <= 16, 16'(k));
    tick();
    tick();
    check("ovf_count", {27'h0, count}, 32'd16);
    check("ovf_almost_full", {31'h0, almost_full}, 32'd1);
    check("ovf_flag", {31'h0, ovf}, 32'd1);
    check("ovf_drop_cnt", {16'h0, drop_cnt}, 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && bus.out_valid; i++) tick();
    check("drain_valid", {31'h0, bus.out_valid}, 32'd0);
    check("drain_sb_empty", sb.size(), 32'd0);
    check("drain_count", {27'h0, count}, 32'd0);

    // full FIFO with simultaneous push and pop
    bus.out_ready = 1'b0;
    for (int k = 'h21; k <= 'h30; k++) send(33'(k) << 16, 1'b1, 16'(k));
    tick();
    check("refill_count", {27'h0, count}, 32'd16);
    minc = 99;
    for (int i = 0; i <= 20; i++) begin
      bus.in_valid  = (i < 20);
      bus.in_data   = 33'('h41 + i) << 16;
      if (i < 20) sb.push_back(16'('h41 + i));
      bus.out_ready = (i >= 1);
      tick();
      if (int'(count) < minc) minc = int'(count);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("pushpop_min_count", minc, 32'd16);
    check("pushpop_count", {27'h0, count}, 32'd16);
    check("pushpop_drop_cnt", {16'h0, drop_cnt}, 32'd2);

    // ovf_clr colliding with a drop, then a clean clear
    bus.in_valid = 1'b1;
    bus.in_data  = 33'h0_0001_0000;
    tick();
    bus.in_valid = 1'b0;
    ovf_clr      = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_collide_ovf", {31'h0, ovf}, 32'd1);
    check("clr_collide_drop_cnt", {16'h0, drop_cnt}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", {31'h0, ovf}, 32'd0);
    check("clr_drop_cnt", {16'h0, drop_cnt}, 32'd0);
    check("clr_keeps_data", {27'h0, count}, 32'd16);

    // reset mid-stream with 9 entries buffered
    bus.out_ready = 1'b1;
    repeat (7) tick();
    bus.out_ready = 1'b0;
    check("pre_reset_count", {27'h0, count}, 32'd9);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    sb.delete();
    check("mid_rst_count", {27'h0, count}, 32'd0);
    check("mid_rst_valid", {31'h0, bus.out_valid}, 32'd0);
    check("mid_rst_ovf", {31'h0, ovf}, 32'd0);
    check("mid_rst_drop_cnt", {16'h0, drop_cnt}, 32'd0);
    check("mid_rst_sat_cnt", {16'h0, sat_cnt}, 32'd0);
    check("mid_rst_almost_full", {31'h0, almost_full}, 32'd0);
    bus.out_ready = 1'b1;
    send(33'h0_4000_0000, 1'b1, 16'h4000);
    tick();
    check("post_rst_valid", {31'h0, bus.out_valid}, 32'd1);
    check("post_rst_data", {16'h0, bus.out_data}, 32'h4000);
    tick();
    tick();
    check("final_sb_empty", sb.size(), 32'd0);
    check("final_valid", {31'h0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
